// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the time-shared byte-serial adder scheduler.
package adder_sched_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/adder_8.sv
// 8-bit ripple adder slice with unsigned carry-out and signed overflow flag.
module adder_8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_ci,
    output logic [7:0] o_s,
    output logic       o_co,
    output logic       o_of
);

    logic [7:0] w_low;
    logic [1:0] w_high;

    // w_low[7] is the carry into bit 7, needed for the overflow flag
    assign w_low  = {1'b0, i_a[6:0]} + {1'b0, i_b[6:0]} + {7'd0, i_ci};
    assign w_high = {1'b0, i_a[7]} + {1'b0, i_b[7]} + {1'b0, w_low[7]};

    assign o_s  = {w_high[0], w_low[6:0]};
    assign o_co = w_high[1];
    assign o_of = w_high[1] ^ w_low[7];

endmodule

// File: rtl/adder_share_sched.sv
// Round-robin scheduler sharing one adder_8 between two requesters; multi-byte
// adds run LSB first, one byte per cycle, with the carry held in a register.
//   state | meaning
//   IDLE  | waiting for a request; ready offered to the granted requester
//   RUN   | one byte per cycle through the shared adder
//   DONE  | result presented until the consumer takes it
module adder_share_sched
    import adder_sched_pkg::*;
#(
    parameter  int NBYTES = 2,
    localparam int W      = BYTE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_ci,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_ci,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [W-1:0] resp_sum,
    output logic         resp_co,
    output logic         resp_of
);

    localparam int                IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    req_id_t          r_last_grant;
    req_id_t          r_id;
    req_id_t          w_grant_id;
    logic             w_grant_vld;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic             r_co;
    logic             r_of;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       w_byte_a;
    logic [7:0]       w_byte_b;
    logic [7:0]       w_byte_s;
    logic             w_add_co;
    logic             w_add_of;

    always_comb begin
        w_grant_vld = req0_valid | req1_valid;
        w_grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    always_comb begin
        w_byte_a = '0;
        w_byte_b = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_byte_a = r_a[i*BYTE_W +: BYTE_W];
                w_byte_b = r_b[i*BYTE_W +: BYTE_W];
            end
        end
    end

    adder_8 u_adder (
        .i_a  (w_byte_a),
        .i_b  (w_byte_b),
        .i_ci (r_carry),
        .o_s  (w_byte_s),
        .o_co (w_add_co),
        .o_of (w_add_of)
    );

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = RUN;
                    req0_ready  = ~w_grant_id;
                    req1_ready  = w_grant_id;
                end
            end
            RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_carry      <= 1'b0;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_co         <= 1'b0;
            r_of         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_grant_vld) begin
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_a          <= w_grant_id ? req1_a  : req0_a;
                        r_b          <= w_grant_id ? req1_b  : req0_b;
                        r_carry      <= w_grant_id ? req1_ci : req0_ci;
                        r_idx        <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[i*BYTE_W +: BYTE_W] <= w_byte_s;
                        end
                    end
                    r_carry <= w_add_co;
                    // Only the final byte's flags describe the full-width add
                    if (r_idx == LAST_IDX) begin
                        r_co <= w_add_co;
                        r_of <= w_add_of;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_id  = r_id;
    assign resp_sum = r_sum;
    assign resp_co  = r_co;
    assign resp_of  = r_of;

endmodule

// File: tb/tb_adder_share_sched.sv
// Self-checking bench for adder_share_sched: NBYTES=2 main instance plus an
// NBYTES=1 instance; results checked through an in-order scoreboard.
module tb_adder_share_sched;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_ci;
    logic          req1_valid, req1_ready, req1_ci;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          resp_valid, resp_ready, resp_id, resp_co, resp_of;
    logic [W-1:0]  resp_sum;

    logic          n1_req0_valid, n1_req0_ready, n1_req0_ci;
    logic          n1_req1_valid, n1_req1_ready, n1_req1_ci;
    logic [7:0]    n1_req0_a, n1_req0_b, n1_req1_a, n1_req1_b;
    logic          n1_resp_valid, n1_resp_ready, n1_resp_id, n1_resp_co, n1_resp_of;
    logic [7:0]    n1_resp_sum;

    always #5 clk = ~clk;

    adder_share_sched #(.NBYTES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_co(resp_co), .resp_of(resp_of)
    );

    adder_share_sched #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(n1_req0_valid), .req0_ready(n1_req0_ready), .req0_a(n1_req0_a), .req0_b(n1_req0_b), .req0_ci(n1_req0_ci),
        .req1_valid(n1_req1_valid), .req1_ready(n1_req1_ready), .req1_a(n1_req1_a), .req1_b(n1_req1_b), .req1_ci(n1_req1_ci),
        .resp_valid(n1_resp_valid), .resp_ready(n1_resp_ready), .resp_id(n1_resp_id),
        .resp_sum(n1_resp_sum), .resp_co(n1_resp_co), .resp_of(n1_resp_of)
    );

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
        logic         co;
        logic         of;
    } exp_t;

    typedef struct packed {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] sum;
        logic         co;
        logic         of;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci);
        logic [W:0] full;
        exp_t e;
        full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e.id  = id;
        e.sum = full[W-1:0];
        e.co  = full[W];
        e.of  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Scoreboard: a handshake seen at a negedge completes on the next posedge
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id",  {31'd0, resp_id}, {31'd0, e.id});
                chk("resp_sum", {16'd0, resp_sum}, {16'd0, e.sum});
                chk("resp_co",  {31'd0, resp_co}, {31'd0, e.co});
                chk("resp_of",  {31'd0, resp_of}, {31'd0, e.of});
            end
        end
    end

    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input exp_t e);
        logic got;
        @(posedge clk); #1;
        if (id) begin
            req1_a = a; req1_b = b; req1_ci = ci; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_ci = ci; req0_valid = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((id && req1_ready) || (!id && req0_ready)) begin
                got = 1'b1;
                break;
            end
        end
        chk("issue_accept", {31'd0, got}, 32'd1);
        if (got) sb.push_back(e);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_resp();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("resp_timeout", {31'd0, done}, 32'd1);
        sb.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       got;
        logic       exp_grant;
        logic       seen;
        int         lat;
        exp_t       e;

        vecs[0] = '{id: 1'b0, a: 16'h7FFF, b: 16'h0001, ci: 1'b0, sum: 16'h8000, co: 1'b0, of: 1'b1};
        vecs[1] = '{id: 1'b0, a: 16'hFFFF, b: 16'h0001, ci: 1'b0, sum: 16'h0000, co: 1'b1, of: 1'b0};
        vecs[2] = '{id: 1'b1, a: 16'h8000, b: 16'h8000, ci: 1'b0, sum: 16'h0000, co: 1'b1, of: 1'b1};
        vecs[3] = '{id: 1'b0, a: 16'hFFFF, b: 16'h0000, ci: 1'b1, sum: 16'h0000, co: 1'b1, of: 1'b0};
        vecs[4] = '{id: 1'b1, a: 16'h1234, b: 16'h1111, ci: 1'b1, sum: 16'h2346, co: 1'b0, of: 1'b0};
        vecs[5] = '{id: 1'b0, a: 16'h8000, b: 16'hFFFF, ci: 1'b0, sum: 16'h7FFF, co: 1'b1, of: 1'b1};

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ci = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ci = 1'b0;
        resp_ready = 1'b1;
        n1_req0_valid = 1'b0; n1_req0_a = '0; n1_req0_b = '0; n1_req0_ci = 1'b0;
        n1_req1_valid = 1'b0; n1_req1_a = '0; n1_req1_b = '0; n1_req1_ci = 1'b0;
        n1_resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_id",    {31'd0, resp_id}, 32'd0);
        chk("rst_resp_sum",   {16'd0, resp_sum}, 32'd0);
        chk("rst_resp_co",    {31'd0, resp_co}, 32'd0);
        chk("rst_resp_of",    {31'd0, resp_of}, 32'd0);
        chk("rst_ready",      {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("rst_n1_valid",   {31'd0, n1_resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Carry across bytes and accept-to-valid latency
        @(posedge clk); #1;
        req0_a = 16'h00FF; req0_b = 16'h0001; req0_ci = 1'b0; req0_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req0_ready) begin got = 1'b1; break; end
        end
        chk("t1_accept", {31'd0, got}, 32'd1);
        sb.push_back('{id: 1'b0, sum: 16'h0100, co: 1'b0, of: 1'b0});
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) req0_valid = 1'b0;
            if (resp_valid) break;
        end
        chk("t1_latency", lat, 32'd3);
        wait_resp();

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].ci,
                  '{id: vecs[i].id, sum: vecs[i].sum, co: vecs[i].co, of: vecs[i].of});
            wait_resp();
        end

        // Arbitration: both valid after reset, held for 4 grants
        do_reset();
        @(posedge clk); #1;
        req0_a = 16'h0001; req0_b = 16'h0001; req0_ci = 1'b0; req0_valid = 1'b1;
        req1_a = 16'h0100; req1_b = 16'h0200; req1_ci = 1'b0; req1_valid = 1'b1;
        exp_grant = 1'b0;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin got = 1'b1; break; end
            end
            chk("arb_grant_seen", {31'd0, got}, 32'd1);
            chk("arb_grant_id", {30'd0, req0_ready, req1_ready}, exp_grant ? 32'd1 : 32'd2);
            if (exp_grant) sb.push_back(model(1'b1, req1_a, req1_b, req1_ci));
            else           sb.push_back(model(1'b0, req0_a, req0_b, req0_ci));
            exp_grant = ~exp_grant;
            @(posedge clk);
        end
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_resp();

        // req1 alone is granted in the first IDLE cycle
        @(posedge clk); #1;
        req1_a = 16'hABCD; req1_b = 16'h1111; req1_ci = 1'b0; req1_valid = 1'b1;
        @(negedge clk);
        chk("req1_alone_ready", {30'd0, req0_ready, req1_ready}, 32'd1);
        if (req1_ready) sb.push_back(model(1'b1, 16'hABCD, 16'h1111, 1'b0));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_resp();

        // Backpressure: hold resp_ready low in DONE
        @(posedge clk); #1;
        resp_ready = 1'b0;
        e = model(1'b0, 16'h4321, 16'h1234, 1'b1);
        issue(1'b0, 16'h4321, 16'h1234, 1'b1, e);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (resp_valid) begin seen = 1'b1; break; end
        end
        chk("bp_valid_seen", {31'd0, seen}, 32'd1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_sum",   {16'd0, resp_sum}, {16'd0, e.sum});
            chk("bp_flags", {29'd0, resp_id, resp_co, resp_of}, {29'd0, e.id, e.co, e.of});
            chk("bp_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_back_to_idle", {31'd0, resp_valid}, 32'd0);
        chk("bp_sb_empty", sb.size(), 32'd0);
        sb.delete();

        // Reset during RUN aborts the operation
        @(posedge clk); #1;
        req0_a = 16'h1111; req0_b = 16'h2222; req0_ci = 1'b0; req0_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req0_ready) begin got = 1'b1; break; end
        end
        chk("rr_accept", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_outputs", {13'd0, resp_valid, resp_id, resp_co, resp_of, resp_sum}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("rr_no_resp", {31'd0, seen}, 32'd0);
        issue(1'b0, 16'h1234, 16'h1111, 1'b0, '{id: 1'b0, sum: 16'h2345, co: 1'b0, of: 1'b0});
        wait_resp();

        // NBYTES=1 instance: single RUN cycle
        @(posedge clk); #1;
        n1_req0_a = 8'hFF; n1_req0_b = 8'h01; n1_req0_ci = 1'b0; n1_req0_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (n1_req0_ready) begin got = 1'b1; break; end
        end
        chk("n1_accept", {31'd0, got}, 32'd1);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) n1_req0_valid = 1'b0;
            if (n1_resp_valid) break;
        end
        chk("n1_latency", lat, 32'd2);
        chk("n1_sum", {24'd0, n1_resp_sum}, 32'h00);
        chk("n1_flags", {29'd0, n1_resp_id, n1_resp_co, n1_resp_of}, 32'b010);
        @(negedge clk);
        chk("n1_idle", {31'd0, n1_resp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
